// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM and PC blocks of the sequential layer.
package ram_pkg;

   // Two-state lifecycle: sweep memory to zero, then serve reads and writes.
   typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

   // Address width for a memory of the given depth (never below one bit).
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/register_n.sv
// One WIDTH-bit storage word; written when load is high at the rising edge.
// Deliberately reset-free: the owning RAM clears its words with a sweep.
module register_n #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   // Capture the new word only on an enabled edge.
   always_ff @(posedge clk) begin
      if (load) begin
         out <= in;
      end
   end

endmodule

// File: rtl/ram_nway.sv
// Parametrised DEPTH x WIDTH word RAM with a combinational read port and a
// post-reset clear sweep that zeroes every word while busy is high.
// Optional feature macro: RAM_NWAY_BYPASS_EN (write-through forwarding of in
// onto out during an accepted write cycle).
module ram_nway
   import ram_pkg::*;
#(
   parameter  int unsigned WIDTH  = 16,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);

   ram_state_t        state_q;
   ram_state_t        state_d;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [ADDR_W-1:0] clr_ptr_d;

   logic [DEPTH-1:0]  word_we;
   logic [WIDTH-1:0]  word_d;
   logic [WIDTH-1:0]  word_q [DEPTH];
   logic [WIDTH-1:0]  stored_rd;

   // State and clear pointer; reset parks the sweep at word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Next state: step the pointer once per cycle, leave after the last word.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d   = ST_IDLE;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   assign busy = (state_q == ST_CLEAR);

   // Write decode: the sweep owns the write port while clearing, the user
   // port only when idle; out-of-range addresses match no word.
   always_comb begin
      word_we = '0;
      word_d  = busy ? '0 : in;
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy) begin
               word_we[i] = (clr_ptr_q == ADDR_W'(i));
            end else begin
               word_we[i] = load && (address == ADDR_W'(i));
            end
         end
      end
   end

   // One storage register per word.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      register_n #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk  (clk),
         .load (word_we[g]),
         .in   (word_d),
         .out  (word_q[g])
      );
   end

   // Read mux: an address past the last word reads as zero.
   always_comb begin
      stored_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) begin
            stored_rd = word_q[i];
         end
      end
   end

`ifdef RAM_NWAY_BYPASS_EN
   logic addr_ok;
   assign addr_ok = (32'(address) < DEPTH);

   // Output: zero while clearing, otherwise forward an accepted write.
   always_comb begin
      out = '0;
      if (!busy) begin
         if (load && addr_ok) begin
            out = in;
         end else begin
            out = stored_rd;
         end
      end
   end
`else
   // Output: zero while clearing, otherwise the stored word.
   always_comb begin
      out = '0;
      if (!busy) begin
         out = stored_rd;
      end
   end
`endif

endmodule
